// File: rtl/ladybird_lsu_cache_adapter.sv
`default_nettype none
// ============================================================================
// Module      : ladybird_lsu_cache_adapter
// Description : Single-outstanding load/store front-end for the data cache:
//               aligns stores, issues cache ops, extracts/extends load data.
// Revision    : 1.0 - initial release
// ============================================================================
module ladybird_lsu_cache_adapter #(
    parameter int XLEN   = 32,
    parameter int LINE_W = 7
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [XLEN-1:0]     req_addr_i,
    input  logic [XLEN-1:0]     req_wdata_i,
    input  logic                req_write_i,
    input  logic [2:0]          req_funct3_i,
    input  logic                req_uncache_i,
    input  logic                req_fence_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [XLEN-1:0]     rsp_data_o,
    output logic                rsp_error_o,
    output logic                c_valid_o,
    input  logic                c_ready_i,
    output logic [XLEN-1:0]     c_addr_o,
    output logic [XLEN-1:0]     c_data_o,
    output logic [XLEN/8-1:0]   c_wen_o,
    output logic                c_uncache_o,
    output logic                c_flush_o,
    output logic                c_invalidate_o,
    input  logic                c_rvalid_i,
    input  logic [XLEN-1:0]     c_raddr_i,
    input  logic [2**LINE_W-1:0] c_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            write_q, write_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            uncache_q, uncache_d;
    logic            fence_q, fence_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_error_q, rsp_error_d;
    logic            seen_drop_q, seen_drop_d;

    logic                w_req_err;
    logic                w_issue;
    logic                w_store;
    logic [LINE_W-6:0]   w_wsel;
    logic [XLEN-1:0]     w_word;
    logic [XLEN-1:0]     w_shift;
    logic [XLEN-1:0]     w_load;
    logic                w_sext;
    logic                w_addr_match;
    logic                w_unused_raddr;

    // Fences carry no meaningful funct3/addr, so they can never be malformed.
    always_comb begin
        w_req_err = 1'b0;
        case (req_funct3_i)
            3'd0, 3'd4: w_req_err = 1'b0;
            3'd1, 3'd5: w_req_err = req_addr_i[0];
            3'd2:       w_req_err = (req_addr_i[1:0] != 2'b00);
            default:    w_req_err = 1'b1;
        endcase
        if (req_write_i && req_funct3_i[2]) begin
            w_req_err = 1'b1;
        end
        if (req_fence_i) begin
            w_req_err = 1'b0;
        end
    end

    assign w_wsel       = addr_q[LINE_W-4:2];
    assign w_word       = c_rdata_i[w_wsel*XLEN +: XLEN];
    assign w_shift      = w_word >> {addr_q[1:0], 3'b000};
    assign w_sext       = ~funct3_q[2];
    assign w_addr_match = (c_raddr_i[XLEN-1:2] == addr_q[XLEN-1:2]);
    assign w_unused_raddr = ^c_raddr_i[1:0];

    always_comb begin
        case (funct3_q[1:0])
            2'd0:    w_load = {{(XLEN-8){w_sext & w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_load = {{(XLEN-16){w_sext & w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_word;
        endcase
    end

    // Cache-side outputs are only driven while the request is being offered.
    assign w_issue        = (state_q == S_ISSUE);
    assign w_store        = w_issue & write_q & ~fence_q;
    assign c_addr_o       = (w_issue && !fence_q) ? addr_q : '0;
    assign c_data_o       = w_store ? (wdata_q << {addr_q[1:0], 3'b000}) : '0;
    assign c_uncache_o    = w_issue & uncache_q;
    assign c_flush_o      = w_issue & fence_q;
    assign c_invalidate_o = 1'b0;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_error_o    = rsp_error_q;

    always_comb begin
        c_wen_o = '0;
        if (w_store) begin
            case (funct3_q[1:0])
                2'd0:    c_wen_o = (XLEN/8)'(1) << addr_q[1:0];
                2'd1:    c_wen_o = (XLEN/8)'(3) << addr_q[1:0];
                default: c_wen_o = '1;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        uncache_d   = uncache_q;
        fence_d     = fence_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        seen_drop_d = seen_drop_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        c_valid_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d      = req_addr_i;
                    wdata_d     = req_wdata_i;
                    write_d     = req_write_i;
                    funct3_d    = req_funct3_i;
                    uncache_d   = req_uncache_i;
                    fence_d     = req_fence_i;
                    rsp_data_d  = '0;
                    rsp_error_d = w_req_err;
                    seen_drop_d = 1'b0;
                    state_d     = w_req_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                c_valid_o = 1'b1;
                if (!c_ready_i) begin
                    seen_drop_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A flush is done once the cache has gone busy and come back.
                if (fence_q) begin
                    if (!c_ready_i) begin
                        seen_drop_d = 1'b1;
                    end else if (seen_drop_q) begin
                        state_d = S_RESP;
                    end
                end else if (c_rvalid_i && w_addr_match) begin
                    rsp_data_d = write_q ? '0 : w_load;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            funct3_q    <= 3'd0;
            uncache_q   <= 1'b0;
            fence_q     <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            seen_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            uncache_q   <= uncache_d;
            fence_q     <= fence_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            seen_drop_q <= seen_drop_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ladybird_lsu_cache_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ladybird_lsu_cache_adapter
// Description : Directed scoreboard bench for the LSU cache adapter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ladybird_lsu_cache_adapter;

    localparam int XLEN   = 32;
    localparam int LINE_W = 7;

    logic         clk = 1'b0;
    logic         nrst;
    logic         req_valid, req_ready;
    logic [31:0]  req_addr, req_wdata;
    logic         req_write, req_uncache, req_fence;
    logic [2:0]   req_funct3;
    logic         rsp_valid, rsp_ready, rsp_error;
    logic [31:0]  rsp_data;
    logic         c_valid, c_ready, c_uncache, c_flush, c_invalidate, c_rvalid;
    logic [31:0]  c_addr, c_data, c_raddr;
    logic [3:0]   c_wen;
    logic [127:0] c_rdata;

    int ncmp  = 0;
    int nfail = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    ladybird_lsu_cache_adapter #(.XLEN(XLEN), .LINE_W(LINE_W)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_write_i(req_write), .req_funct3_i(req_funct3),
        .req_uncache_i(req_uncache), .req_fence_i(req_fence),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_error_o(rsp_error),
        .c_valid_o(c_valid), .c_ready_i(c_ready),
        .c_addr_o(c_addr), .c_data_o(c_data), .c_wen_o(c_wen),
        .c_uncache_o(c_uncache), .c_flush_o(c_flush), .c_invalidate_o(c_invalidate),
        .c_rvalid_i(c_rvalid), .c_raddr_i(c_raddr), .c_rdata_i(c_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // Response side of the scoreboard: compare at each handshake.
    always @(negedge clk) begin
        logic [32:0] e;
        if (nrst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chkb("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e[31:0]);
                chkb("rsp_error", rsp_error, e[32]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic unc, input logic fen,
                        input logic [31:0] ed, input logic ee);
        tick();
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a;
        req_wdata = wd; req_uncache = unc; req_fence = fen;
        settle();
        chkb("req_ready_idle", req_ready, 1'b1);
        exp_q.push_back({ee, ed});
        tick();
        req_valid = 1'b0; req_write = 1'b1; req_funct3 = 3'd3;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
        req_uncache = ~unc; req_fence = 1'b0;
    endtask

    task automatic load_hit(input logic [2:0] f3, input logic [31:0] a,
                            input logic [127:0] line, input logic [31:0] ed,
                            input logic unc);
        send(1'b0, f3, a, 32'h5555_5555, unc, 1'b0, ed, 1'b0);
        settle();
        chkb("ld_c_valid", c_valid, 1'b1);
        chk("ld_c_addr", c_addr, a);
        chk("ld_c_wen", {28'b0, c_wen}, 32'd0);
        chkb("ld_c_uncache", c_uncache, unc);
        chkb("ld_c_flush", c_flush, 1'b0);
        chkb("ld_req_ready_busy", req_ready, 1'b0);
        tick();
        c_rvalid = 1'b1; c_raddr = a; c_rdata = line;
        settle();
        chkb("ld_c_valid_wait", c_valid, 1'b0);
        chkb("ld_rsp_early", rsp_valid, 1'b0);
        tick();
        c_rvalid = 1'b0;
        settle();
        chkb("ld_rsp_valid_t3", rsp_valid, 1'b1);
        tick();
        settle();
        chkb("ld_req_ready_t4", req_ready, 1'b1);
        chkb("ld_rsp_cleared", rsp_valid, 1'b0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ewen, input logic [31:0] edata);
        send(1'b1, f3, a, wd, 1'b0, 1'b0, 32'd0, 1'b0);
        settle();
        chkb("st_c_valid", c_valid, 1'b1);
        chk("st_c_wen", {28'b0, c_wen}, {28'b0, ewen});
        chk("st_c_data", c_data, edata);
        chk("st_c_addr", c_addr, a);
        tick();
        c_rvalid = 1'b1; c_raddr = a + 32'h100;
        settle();
        chkb("st_nomatch_ignored", rsp_valid, 1'b0);
        tick();
        c_raddr = {a[31:2], 2'b00};
        settle();
        chkb("st_rsp_early", rsp_valid, 1'b0);
        tick();
        c_rvalid = 1'b0;
        settle();
        chkb("st_rsp_valid", rsp_valid, 1'b1);
        tick();
    endtask

    task automatic bad(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        send(wr, f3, a, 32'h1234_5678, 1'b0, 1'b0, 32'd0, 1'b1);
        settle();
        chkb("err_rsp_t1", rsp_valid, 1'b1);
        chkb("err_no_c_valid", c_valid, 1'b0);
        tick();
        settle();
        chkb("err_back_idle", req_ready, 1'b1);
        chkb("err_c_valid_after", c_valid, 1'b0);
    endtask

    task automatic check_reset_outputs();
        chkb("rst_req_ready", req_ready, 1'b1);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chkb("rst_rsp_error", rsp_error, 1'b0);
        chkb("rst_c_valid", c_valid, 1'b0);
        chk("rst_c_addr", c_addr, 32'd0);
        chk("rst_c_data", c_data, 32'd0);
        chk("rst_c_wen", {28'b0, c_wen}, 32'd0);
        chkb("rst_c_uncache", c_uncache, 1'b0);
        chkb("rst_c_flush", c_flush, 1'b0);
        chkb("rst_c_invalidate", c_invalidate, 1'b0);
    endtask

    logic [127:0] line;

    initial begin
        nrst = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
        req_funct3 = 3'd0; req_uncache = 1'b0; req_fence = 1'b0;
        rsp_ready = 1'b1; c_ready = 1'b1; c_rvalid = 1'b0; c_raddr = '0; c_rdata = '0;
        repeat (3) tick();
        nrst = 1'b1;
        settle();
        check_reset_outputs();

        // Loads: word select and sign/zero extension
        line = {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
        load_hit(3'd2, 32'h0000_0104, line, 32'hDEAD_BEEF, 1'b0);
        line = {32'h4444_4444, 32'h3333_3333, 32'h8011_2233, 32'h1111_1111};
        load_hit(3'd0, 32'h0000_0107, line, 32'hFFFF_FF80, 1'b0);
        load_hit(3'd4, 32'h0000_0107, line, 32'h0000_0080, 1'b0);
        load_hit(3'd1, 32'h0000_0106, line, 32'hFFFF_8011, 1'b0);
        load_hit(3'd5, 32'h0000_0106, line, 32'h0000_8011, 1'b0);
        load_hit(3'd0, 32'h0000_0104, line, 32'h0000_0033, 1'b1);

        // Stores: lane alignment of data and byte enables
        store(3'd0, 32'h0000_0102, 32'h0000_00AB, 4'b0100, 32'h00AB_0000);
        store(3'd1, 32'h0000_0102, 32'h0000_1234, 4'b1100, 32'h1234_0000);
        store(3'd2, 32'h0000_0100, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);

        // Misaligned / illegal requests
        bad(1'b0, 3'd1, 32'h0000_0101);
        bad(1'b0, 3'd2, 32'h0000_0102);
        bad(1'b0, 3'd3, 32'h0000_0100);
        bad(1'b1, 3'd4, 32'h0000_0100);
        bad(1'b0, 3'd6, 32'h0000_0100);

        // Backpressure on both sides with a slow miss
        line = {32'h4444_4444, 32'hCAFE_F00D, 32'h2222_2222, 32'h1111_1111};
        send(1'b0, 3'd2, 32'h0000_0208, 32'd0, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);
        c_ready = 1'b0; rsp_ready = 1'b0;
        c_rvalid = 1'b1; c_raddr = 32'h0000_0208; c_rdata = line;
        for (int i = 0; i < 3; i++) begin
            settle();
            chkb("stall_c_valid", c_valid, 1'b1);
            chk("stall_c_addr", c_addr, 32'h0000_0208);
            chk("stall_c_wen", {28'b0, c_wen}, 32'd0);
            chkb("stall_req_ready", req_ready, 1'b0);
            tick();
            c_rvalid = 1'b0;
        end
        c_ready = 1'b1;
        settle();
        chkb("stall_c_valid_hs", c_valid, 1'b1);
        chk("stall_c_addr_hs", c_addr, 32'h0000_0208);
        tick();
        for (int i = 0; i < 20; i++) begin
            c_rvalid = (i == 5); c_raddr = 32'h0000_0308;
            settle();
            chkb("miss_rsp_wait", rsp_valid, 1'b0);
            chkb("miss_req_ready", req_ready, 1'b0);
            tick();
        end
        c_rvalid = 1'b1; c_raddr = 32'h0000_020B;
        settle();
        chkb("miss_rsp_early", rsp_valid, 1'b0);
        tick();
        c_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c_rvalid = (i == 2); c_raddr = 32'h0000_0208; c_rdata = '0;
            settle();
            chkb("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_data", rsp_data, 32'hCAFE_F00D);
            chkb("hold_req_ready", req_ready, 1'b0);
            tick();
        end
        c_rvalid = 1'b0; rsp_ready = 1'b1;
        settle();
        chkb("hold_release", rsp_valid, 1'b1);
        tick();
        settle();
        chkb("hold_idle", req_ready, 1'b1);

        // Fence: completes one cycle after c_ready returns from a long drop
        send(1'b0, 3'd7, 32'h0000_0123, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 1'b0);
        settle();
        chkb("fence_c_valid", c_valid, 1'b1);
        chkb("fence_c_flush", c_flush, 1'b1);
        chk("fence_c_addr", c_addr, 32'd0);
        chkb("fence_c_invalidate", c_invalidate, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            settle();
            chkb("fence_no_drop_yet", rsp_valid, 1'b0);
            tick();
        end
        c_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            settle();
            chkb("fence_dropped", rsp_valid, 1'b0);
            tick();
        end
        c_ready = 1'b1;
        settle();
        chkb("fence_ready_back", rsp_valid, 1'b0);
        tick();
        settle();
        chkb("fence_rsp", rsp_valid, 1'b1);
        tick();

        // Fence with the drop inside the issue handshake
        send(1'b0, 3'd0, 32'h0000_0040, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);
        c_ready = 1'b0;
        settle();
        chkb("fence2_c_valid", c_valid, 1'b1);
        tick();
        c_ready = 1'b1;
        settle();
        chkb("fence2_c_valid_hs", c_valid, 1'b1);
        tick();
        settle();
        chkb("fence2_wait", rsp_valid, 1'b0);
        tick();
        settle();
        chkb("fence2_rsp", rsp_valid, 1'b1);
        tick();

        // Reset in the middle of a fence wait
        send(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);
        settle();
        tick();
        c_ready = 1'b0;
        settle();
        tick();
        nrst = 1'b0;
        exp_q.delete();
        settle();
        tick();
        nrst = 1'b1; c_ready = 1'b1;
        settle();
        check_reset_outputs();
        tick();
        settle();
        chkb("post_rst_no_rsp", rsp_valid, 1'b0);

        line = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h0BAD_F00D};
        load_hit(3'd2, 32'h8000_0000, line, 32'h0BAD_F00D, 1'b1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
